// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared state encoding and RV32I constants for the run controller.
package run_ctrl_pkg;
    typedef enum logic [1:0] {S_HOLD, S_RUN, S_DONE} state_t;
    localparam logic [31:0] INST_ECALL = 32'h00000073;
    localparam logic [4:0] GP_ADDR = 5'd3;
endpackage

// File: rtl/run_trace_buf.sv
// run_trace_buf: ring buffer of retired PCs with a most-recent-first combinational read port.
module run_trace_buf #(
    parameter int XLEN = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [XLEN-1:0]          wdata,
    input  logic [$clog2(DEPTH)-1:0] idx,
    output logic [XLEN-1:0]          rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [XLEN-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    always_ff @(posedge clk)
        if (we) mem[wptr] <= wdata;
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            count <= '0;
        end else if (we) begin
            wptr <= wptr + AW'(1);
            count <= count == (AW+1)'(DEPTH) ? count : count + (AW+1)'(1);
        end
    end
    // wptr points at the next free slot, so the newest entry sits one behind it
    always_comb rdata = {1'b0, idx} >= count ? '0 : mem[wptr - AW'(1) - idx];
endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: CPU reset sequencer, retire/cycle counters, halt detection and gp-based verdict.
// Optional PC trace ring enabled by defining RUN_CTRL_TRACE_EN.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int CNT_W = 32,
    parameter int RESET_CYCLES = 10,
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int LOOP_LIMIT = 4,
    parameter int TRACE_DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           retire_valid,
    input  logic [XLEN-1:0]                retire_pc,
    input  logic [31:0]                    retire_inst,
    input  logic                           rf_we,
    input  logic [4:0]                     rf_waddr,
    input  logic [XLEN-1:0]                rf_wdata,
`ifdef RUN_CTRL_TRACE_EN
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [XLEN-1:0]                trace_pc,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count,
`endif
    output logic                           cpu_reset,
    output logic                           done,
    output logic                           pass,
    output logic                           fail,
    output logic                           timeout,
    output logic [XLEN-1:0]                fail_code,
    output logic [CNT_W-1:0]               cycle_count,
    output logic [CNT_W-1:0]               retire_count
);
    localparam int HW = $clog2(RESET_CYCLES + 1);
    localparam int LW = $clog2(LOOP_LIMIT + 1);
    state_t state;
    logic [HW-1:0] hold_cnt;
    logic [LW-1:0] loop_cnt;
    logic [XLEN-1:0] last_pc, gp_shadow, gp_now;
    logic gp_wr, same_pc, halt, expired, gp_pass;
    always_comb begin
        gp_wr = rf_we && rf_waddr == GP_ADDR;
        gp_now = gp_wr ? rf_wdata : gp_shadow;
        gp_pass = gp_now == XLEN'(1);
        same_pc = retire_valid && retire_pc == last_pc;
        halt = retire_valid && (retire_inst == INST_ECALL || (same_pc && loop_cnt == LW'(LOOP_LIMIT - 1)));
        expired = cycle_count == CNT_W'(TIMEOUT_CYCLES - 1);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_HOLD;
            hold_cnt <= '0;
            loop_cnt <= '0;
            last_pc <= '0;
            gp_shadow <= '0;
            cycle_count <= '0;
            retire_count <= '0;
            fail_code <= '0;
            cpu_reset <= 1'b1;
            done <= 1'b0;
            pass <= 1'b0;
            fail <= 1'b0;
            timeout <= 1'b0;
        end else begin
            case (state)
                S_HOLD: begin
                    hold_cnt <= hold_cnt + HW'(1);
                    if (hold_cnt == HW'(RESET_CYCLES - 1)) begin
                        state <= S_RUN;
                        cpu_reset <= 1'b0;
                    end
                end
                S_RUN: begin
                    cycle_count <= &cycle_count ? cycle_count : cycle_count + CNT_W'(1);
                    if (retire_valid) retire_count <= &retire_count ? retire_count : retire_count + CNT_W'(1);
                    if (gp_wr) gp_shadow <= rf_wdata;
                    if (same_pc) loop_cnt <= loop_cnt + LW'(1);
                    else if (retire_valid) begin
                        loop_cnt <= '0;
                        last_pc <= retire_pc;
                    end
                    // a halt on the budget's last cycle takes precedence over the timeout
                    if (halt) begin
                        state <= S_DONE;
                        cpu_reset <= 1'b1;
                        done <= 1'b1;
                        pass <= gp_pass;
                        fail <= !gp_pass;
                        fail_code <= gp_pass ? '0 : gp_now >> 1;
                    end else if (expired) begin
                        state <= S_DONE;
                        cpu_reset <= 1'b1;
                        done <= 1'b1;
                        fail <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                S_DONE: ;
                default: state <= S_HOLD;
            endcase
        end
    end
`ifdef RUN_CTRL_TRACE_EN
    run_trace_buf #(.XLEN(XLEN), .DEPTH(TRACE_DEPTH)) u_trace (
        .clk(clk),
        .reset(reset),
        .we(state == S_RUN && retire_valid),
        .wdata(retire_pc),
        .idx(trace_idx),
        .rdata(trace_pc),
        .count(trace_count)
    );
`endif
endmodule
